branch_amend_stage_mlane: RTL and testbench

Multi-lane successor of the single-lane PREMEM branch amend stage: a pipeline register between the EXE_up lanes and REEXE that holds an in-order bundle of up to LANES instructions. It selects the oldest lane whose branch needs repair and emits exactly one flush/repair request per bundle. It kills lanes younger than that branch's delay slot and forwards the surviving lanes' results. Sits in PREMEM; lane 0 is always the oldest instruction.

---
 rtl/branch_amend_stage_mlane_pkg.sv | 11 +
 rtl/branch_amend_stage_mlane_oldest_lane_pick.sv | 29 ++
 rtl/branch_amend_stage_mlane.sv | 211 +++++++++++++++++++++
 tb/tb_branch_amend_stage_mlane.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_amend_stage_mlane_pkg.sv
// Shared definitions for the multi-lane PREMEM branch amend stage.
// Holds the repair-action bit layout and the forwarding-mode code used by REEXE.
package branch_amend_stage_mlane_pkg;

    // Bit of the per-lane repair action that marks a branch needing repair.
    localparam int NEED_REPAIR_BIT = 0;

    // Forwarding-mode code under which REEXE consumes results from this stage.
    localparam logic [1:0] FORWARD_MODE_REEXE = 2'd2;

endpackage

// File: rtl/branch_amend_stage_mlane_oldest_lane_pick.sv
// Lowest-index priority picker: lane 0 is the oldest, so the lowest set request wins.
// Produces a one-hot grant, its encoded index and an any-request flag.
module oldest_lane_pick #(
    parameter int LANES = 2,
    parameter int SEL_W = 1
) (
    input  logic [LANES-1:0] req,
    output logic [LANES-1:0] onehot,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        // Walk from the youngest lane down so the oldest requester is the last write.
        for (int i = LANES - 1; i >= 0; i--) begin
            if (req[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = SEL_W'(i);
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/branch_amend_stage_mlane.sv
// Multi-lane PREMEM branch amend stage: holds an in-order bundle, issues one repair flush
// for the oldest mispredicted lane, and kills lanes younger than its delay slot.
// Optional statistics counters are built when BRANCH_AMEND_PERF_EN is defined.
module branch_amend_stage_mlane
    import branch_amend_stage_mlane_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int DATA_W = 32,
    parameter int GPR_W  = 5,
    parameter int CKPT_W = 8,
    parameter int RA_W   = 4,
    parameter int EXC_W  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      up_valid,
    input  logic [LANES-1:0]          up_lane_valid,
    input  logic [LANES*GPR_W-1:0]    up_write_num,
    input  logic [LANES*DATA_W-1:0]   up_vaddr,
    input  logic [LANES*DATA_W-1:0]   up_alu_res,
    input  logic [LANES*DATA_W-1:0]   up_corr_dest,
    input  logic [LANES-1:0]          up_corr_take,
    input  logic [LANES*RA_W-1:0]     up_repair_action,
    input  logic [LANES*CKPT_W-1:0]   up_checkpoint,
    input  logic [LANES-1:0]          up_exc_risk,
    input  logic [LANES-1:0]          up_has_exc,
    input  logic [LANES*EXC_W-1:0]    up_exc_code,
    input  logic                      mem_has_risk,
    input  logic                      exc_occur,
    input  logic                      down_allowin,
    input  logic                      premem_allowin,
    output logic                      allowin,
    output logic                      out_valid,
    output logic [LANES-1:0]          out_lane_valid,
    output logic [LANES*GPR_W-1:0]    out_write_num,
    output logic [LANES*DATA_W-1:0]   out_alu_res,
    output logic [LANES*DATA_W-1:0]   out_vaddr,
    output logic [LANES*EXC_W-1:0]    out_exc_code,
    output logic [LANES-1:0]          out_has_exc,
    output logic                      has_risk,
    output logic                      flush,
    output logic [DATA_W-1:0]         flush_vaddr,
    output logic [DATA_W-1:0]         flush_dest,
    output logic                      flush_take,
    output logic [CKPT_W-1:0]         flush_ckpt,
    output logic [RA_W-1:0]           flush_action,
    output logic [31:0]               perf_mispred,
    output logic [31:0]               perf_hold
);

    localparam int SEL_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic                     has_data;
    logic [LANES-1:0]         lane_valid;
    logic [LANES*GPR_W-1:0]   write_num;
    logic [LANES*DATA_W-1:0]  vaddr;
    logic [LANES*DATA_W-1:0]  alu_res;
    logic [LANES*DATA_W-1:0]  corr_dest;
    logic [LANES-1:0]         corr_take;
    logic [LANES*RA_W-1:0]    repair_action;
    logic [LANES*CKPT_W-1:0]  checkpoint;
    logic [LANES-1:0]         exc_risk;
    logic [LANES-1:0]         has_exc;
    logic [LANES*EXC_W-1:0]   exc_code;

    logic [LANES-1:0] need_rep;
    logic [LANES-1:0] pick_oh;
    logic [SEL_W-1:0] sel;
    logic             any_rep;
    logic             blocked;
    logic [LANES-1:0] keep;
    logic             ready;
    logic             clear;
    logic             load;

    for (genvar g = 0; g < LANES; g++) begin : g_need
        assign need_rep[g] = lane_valid[g] & repair_action[g*RA_W + NEED_REPAIR_BIT];
    end

    oldest_lane_pick #(
        .LANES (LANES),
        .SEL_W (SEL_W)
    ) u_pick (
        .req    (need_rep),
        .onehot (pick_oh),
        .idx    (sel),
        .any    (any_rep)
    );

    // Lanes 0..k gate the flush on exc_risk; lanes 0..k+1 (branch plus delay slot) survive.
    always_comb begin : sel_masks
        logic past;
        logic beyond;
        logic delay;
        blocked = 1'b0;
        keep    = '0;
        past    = 1'b0;
        beyond  = 1'b0;
        delay   = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (!past && lane_valid[i] && exc_risk[i]) blocked = 1'b1;
            past    = past | pick_oh[i];
            keep[i] = !beyond;
            beyond  = beyond | delay;
            delay   = pick_oh[i];
        end
    end

    assign ready     = !(any_rep && mem_has_risk);
    assign out_valid = has_data && ready && premem_allowin;
    assign allowin   = !has_data || (ready && down_allowin);
    assign flush     = has_data && any_rep && !blocked && !mem_has_risk && !exc_occur
                       && out_valid && down_allowin;
    assign has_risk  = mem_has_risk || any_rep || |(lane_valid & exc_risk);

    assign out_lane_valid = lane_valid & ((any_rep && !blocked) ? keep : {LANES{1'b1}});
    assign out_write_num  = write_num;
    assign out_alu_res    = alu_res;
    assign out_vaddr      = vaddr;
    assign out_exc_code   = exc_code;
    assign out_has_exc    = has_exc;

    always_comb begin
        flush_vaddr  = '0;
        flush_dest   = '0;
        flush_take   = 1'b0;
        flush_ckpt   = '0;
        flush_action = '0;
        if (any_rep) begin
            flush_vaddr  = vaddr[int'(sel)*DATA_W +: DATA_W];
            flush_dest   = corr_dest[int'(sel)*DATA_W +: DATA_W];
            flush_take   = corr_take[sel];
            flush_ckpt   = checkpoint[int'(sel)*CKPT_W +: CKPT_W];
            flush_action = repair_action[int'(sel)*RA_W +: RA_W];
        end
    end

    // A flush or CP0 exception discards both the held bundle and whatever arrives with it.
    assign clear = exc_occur || flush || (allowin && premem_allowin && !up_valid);
    assign load  = !clear && allowin && premem_allowin && up_valid;

    // NOTE: state uses non-blocking assignments; lane payload is reset too so that
    // every output, including the flush fields, reads 0 straight out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            has_data      <= 1'b0;
            lane_valid    <= '0;
            write_num     <= '0;
            vaddr         <= '0;
            alu_res       <= '0;
            corr_dest     <= '0;
            corr_take     <= '0;
            repair_action <= '0;
            checkpoint    <= '0;
            exc_risk      <= '0;
            has_exc       <= '0;
            exc_code      <= '0;
        end else if (clear) begin
            has_data      <= 1'b0;
            lane_valid    <= '0;
            write_num     <= '0;
            vaddr         <= '0;
            alu_res       <= '0;
            corr_dest     <= '0;
            corr_take     <= '0;
            repair_action <= '0;
            checkpoint    <= '0;
            exc_risk      <= '0;
            has_exc       <= '0;
            exc_code      <= '0;
        end else if (load) begin
            has_data      <= 1'b1;
            lane_valid    <= up_lane_valid;
            write_num     <= up_write_num;
            vaddr         <= up_vaddr;
            alu_res       <= up_alu_res;
            corr_dest     <= up_corr_dest;
            corr_take     <= up_corr_take;
            repair_action <= up_repair_action;
            checkpoint    <= up_checkpoint;
            exc_risk      <= up_exc_risk;
            has_exc       <= up_has_exc;
            exc_code      <= up_exc_code;
        end
    end

`ifdef BRANCH_AMEND_PERF_EN
    logic        held;
    logic [31:0] mispred_cnt;
    logic [31:0] hold_cnt;

    assign held = has_data && !ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mispred_cnt <= '0;
            hold_cnt    <= '0;
        end else begin
            if (flush) mispred_cnt <= mispred_cnt + 32'd1;
            if (held)  hold_cnt    <= hold_cnt + 32'd1;
        end
    end

    assign perf_mispred = mispred_cnt;
    assign perf_hold    = hold_cnt;
`else
    assign perf_mispred = '0;
    assign perf_hold    = '0;
`endif

endmodule

// File: tb/tb_branch_amend_stage_mlane.sv
// Directed bench for branch_amend_stage_mlane: a 2-lane and a 4-lane instance share stimulus.
// Perf counter expectations follow BRANCH_AMEND_PERF_EN.
module tb_branch_amend_stage_mlane;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         up_valid, mem_has_risk, exc_occur, down_allowin, premem_allowin;
    logic [3:0]   lv, take, risk, hexc;
    logic [19:0]  wn, code;
    logic [127:0] pc, alu, dest;
    logic [15:0]  ra;
    logic [31:0]  ck;

    logic        a2, ov2, hr2, fl2, ftk2;
    logic [1:0]  olv2, ohexc2;
    logic [9:0]  own2, ocode2;
    logic [63:0] oalu2, opc2;
    logic [31:0] fpc2, fdst2, pm2, ph2;
    logic [7:0]  fck2;
    logic [3:0]  fact2;

    logic         a4, ov4, hr4, fl4, ftk4;
    logic [3:0]   olv4, ohexc4;
    logic [19:0]  own4, ocode4;
    logic [127:0] oalu4, opc4;
    logic [31:0]  fpc4, fdst4, pm4, ph4;
    logic [7:0]   fck4;
    logic [3:0]   fact4;

    branch_amend_stage_mlane #(.LANES(2)) u2 (
        .clk(clk), .rst(rst), .up_valid(up_valid), .up_lane_valid(lv[1:0]),
        .up_write_num(wn[9:0]), .up_vaddr(pc[63:0]), .up_alu_res(alu[63:0]),
        .up_corr_dest(dest[63:0]), .up_corr_take(take[1:0]), .up_repair_action(ra[7:0]),
        .up_checkpoint(ck[15:0]), .up_exc_risk(risk[1:0]), .up_has_exc(hexc[1:0]),
        .up_exc_code(code[9:0]), .mem_has_risk(mem_has_risk), .exc_occur(exc_occur),
        .down_allowin(down_allowin), .premem_allowin(premem_allowin), .allowin(a2),
        .out_valid(ov2), .out_lane_valid(olv2), .out_write_num(own2), .out_alu_res(oalu2),
        .out_vaddr(opc2), .out_exc_code(ocode2), .out_has_exc(ohexc2), .has_risk(hr2),
        .flush(fl2), .flush_vaddr(fpc2), .flush_dest(fdst2), .flush_take(ftk2),
        .flush_ckpt(fck2), .flush_action(fact2), .perf_mispred(pm2), .perf_hold(ph2)
    );

    branch_amend_stage_mlane #(.LANES(4)) u4 (
        .clk(clk), .rst(rst), .up_valid(up_valid), .up_lane_valid(lv),
        .up_write_num(wn), .up_vaddr(pc), .up_alu_res(alu),
        .up_corr_dest(dest), .up_corr_take(take), .up_repair_action(ra),
        .up_checkpoint(ck), .up_exc_risk(risk), .up_has_exc(hexc),
        .up_exc_code(code), .mem_has_risk(mem_has_risk), .exc_occur(exc_occur),
        .down_allowin(down_allowin), .premem_allowin(premem_allowin), .allowin(a4),
        .out_valid(ov4), .out_lane_valid(olv4), .out_write_num(own4), .out_alu_res(oalu4),
        .out_vaddr(opc4), .out_exc_code(ocode4), .out_has_exc(ohexc4), .has_risk(hr4),
        .flush(fl4), .flush_vaddr(fpc4), .flush_dest(fdst4), .flush_take(ftk4),
        .flush_ckpt(fck4), .flush_action(fact4), .perf_mispred(pm4), .perf_hold(ph4)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_lanes();
        lv = '0; take = '0; risk = '0; hexc = '0;
        wn = '0; code = '0; pc = '0; alu = '0; dest = '0; ra = '0; ck = '0;
    endtask

    task automatic set_lane(input int i, input logic v, input logic [4:0] w,
                            input logic [31:0] p, input logic [31:0] r, input logic [31:0] d,
                            input logic t, input logic [3:0] a, input logic [7:0] c,
                            input logic rk, input logic he, input logic [4:0] ec);
        lv[i] = v; wn[i*5 +: 5] = w; pc[i*32 +: 32] = p; alu[i*32 +: 32] = r;
        dest[i*32 +: 32] = d; take[i] = t; ra[i*4 +: 4] = a; ck[i*8 +: 8] = c;
        risk[i] = rk; hexc[i] = he; code[i*5 +: 5] = ec;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load_bundle();
        up_valid = 1'b1;
        step();
        up_valid = 1'b0;
        clear_lanes();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #2;
        rst = 1'b1;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        up_valid = 1'b0; mem_has_risk = 1'b0; exc_occur = 1'b0;
        down_allowin = 1'b1; premem_allowin = 1'b1;
        clear_lanes();
        #12;
        check("rst_allowin", a2, 1'b1);
        check("rst_out_valid", ov2, 1'b0);
        check("rst_flush", fl2, 1'b0);
        check("rst_lane_valid", olv4, 4'h0);
        check("rst_has_risk", hr4, 1'b0);
        check("rst_perf", {pm4, ph4}, 64'h0);
        rst = 1'b1;
        step();

        // Plain two-lane bundle, briefly held by the lower PREMEM half.
        set_lane(0, 1, 5'd5, 32'h1000, 32'd7, 0, 0, 4'h0, 8'h0, 0, 0, 5'h00);
        set_lane(1, 1, 5'd6, 32'h1004, 32'd9, 0, 0, 4'h0, 8'h0, 0, 1, 5'h0D);
        up_valid = 1'b1;
        #1 check("t1_allowin_empty", a2, 1'b1);
        @(posedge clk); #2;
        up_valid = 1'b0; clear_lanes();
        premem_allowin = 1'b0;
        #1 check("t1_held_out_valid", ov2, 1'b0);
        step();
        check("t1_held_lanes", olv2, 2'b11);
        premem_allowin = 1'b1;
        #1;
        check("t1_out_valid", ov2, 1'b1);
        check("t1_lanes", olv2, 2'b11);
        check("t1_flush", fl2, 1'b0);
        check("t1_write_num", own2, 10'h0C5);
        check("t1_alu0", oalu2[31:0], 32'd7);
        check("t1_has_exc", ohexc2, 2'b10);
        check("t1_exc_code", ocode2, 10'h1A0);
        step();
        check("t1_empty_after", ov2, 1'b0);

        // Lane 0 repair; downstream stall first, then a single flush that drops the next bundle.
        set_lane(0, 1, 5'd0, 32'h8000_0FF0, 32'd0, 32'h8000_1000, 1, 4'h1, 8'h3C, 0, 0, 5'h00);
        set_lane(1, 1, 5'd7, 32'h8000_0FF4, 32'd3, 0, 0, 4'h0, 8'h0, 0, 0, 5'h00);
        load_bundle();
        down_allowin = 1'b0;
        #1;
        check("t2_stall_flush", fl2, 1'b0);
        check("t2_stall_allowin", a2, 1'b0);
        down_allowin = 1'b1;
        set_lane(0, 1, 5'd9, 32'h8000_0FF8, 32'd1, 0, 0, 4'h0, 8'h0, 0, 0, 5'h00);
        up_valid = 1'b1;
        #1;
        check("t2_flush", fl2, 1'b1);
        check("t2_flush_vaddr", fpc2, 32'h8000_0FF0);
        check("t2_flush_dest", fdst2, 32'h8000_1000);
        check("t2_flush_take", ftk2, 1'b1);
        check("t2_flush_ckpt", fck2, 8'h3C);
        check("t2_flush_action", fact2, 4'h1);
        check("t2_lanes", olv2, 2'b11);
        step();
        up_valid = 1'b0; clear_lanes();
        #1;
        check("t2_empty_out_valid", ov2, 1'b0);
        check("t2_empty_flush", fl2, 1'b0);

        // Four lanes, repairs on lanes 1 and 2: lane 1 wins, lane 3 is killed.
        for (int i = 0; i < 4; i++)
            set_lane(i, 1, 5'(i + 1), 32'h2000 + 32'(4 * i), 32'd0, 32'h3000, 0, 4'h0, 8'h0, 0, 0, 5'h00);
        set_lane(1, 1, 5'd2, 32'h2004, 32'd0, 32'h3000, 0, 4'h3, 8'h11, 0, 0, 5'h00);
        set_lane(2, 1, 5'd3, 32'h2008, 32'd0, 32'h4000, 1, 4'h1, 8'h22, 0, 0, 5'h00);
        load_bundle();
        check("t3_lanes4", olv4, 4'b0111);
        check("t3_flush4", fl4, 1'b1);
        check("t3_flush_vaddr4", fpc4, 32'h2004);
        check("t3_flush_action4", fact4, 4'h3);
        check("t3_flush_ckpt4", fck4, 8'h11);
        check("t3_flush2", fl2, 1'b1);
        step();
        check("t3_empty4", ov4, 1'b0);

        // Four lanes, lane 0 repair: only the branch and its delay slot survive.
        for (int i = 0; i < 4; i++)
            set_lane(i, 1, 5'(i + 1), 32'h5000 + 32'(4 * i), 32'd0, 32'h0, 0, 4'h0, 8'h0, 0, 0, 5'h00);
        set_lane(0, 1, 5'd1, 32'h5000, 32'd0, 32'h6000, 0, 4'h1, 8'h44, 0, 0, 5'h00);
        load_bundle();
        check("t4_lanes4", olv4, 4'b0011);
        check("t4_flush_dest4", fdst4, 32'h6000);
        step();

        // An unoccupied lane with NEED_REPAIR set must be ignored.
        set_lane(0, 0, 5'd0, 32'h7000, 32'd0, 32'h7100, 1, 4'h1, 8'h55, 0, 0, 5'h00);
        set_lane(1, 1, 5'd3, 32'h7004, 32'd4, 32'h0, 0, 4'h0, 8'h0, 0, 0, 5'h00);
        load_bundle();
        check("t5_flush", fl2, 1'b0);
        check("t5_lanes", olv2, 2'b10);
        check("t5_out_valid", ov2, 1'b1);
        check("t5_flush_ckpt_zero", fck2, 8'h00);
        check("t5_has_risk", hr2, 1'b0);
        step();

        // Older lane with exc_risk blocks the lane 1 repair; both lanes forward.
        set_lane(0, 1, 5'd8, 32'h9000, 32'd0, 32'h0, 0, 4'h0, 8'h0, 1, 0, 5'h00);
        set_lane(1, 1, 5'd0, 32'h9004, 32'd0, 32'h9100, 1, 4'h1, 8'h66, 0, 0, 5'h00);
        load_bundle();
        check("t6_flush", fl2, 1'b0);
        check("t6_lanes", olv2, 2'b11);
        check("t6_out_valid", ov2, 1'b1);
        check("t6_has_risk", hr2, 1'b1);
        check("t6_sel_vaddr", fpc2, 32'h9004);
        step();

        // CP0 exception alongside a repair-ready bundle: no flush, stage clears, new bundle dropped.
        set_lane(0, 1, 5'd0, 32'hA000, 32'd0, 32'hA100, 0, 4'h1, 8'h77, 0, 0, 5'h00);
        load_bundle();
        set_lane(0, 1, 5'd4, 32'hA004, 32'd2, 32'h0, 0, 4'h0, 8'h0, 0, 0, 5'h00);
        up_valid = 1'b1;
        exc_occur = 1'b1;
        #1 check("t7_flush", fl2, 1'b0);
        step();
        up_valid = 1'b0; exc_occur = 1'b0; clear_lanes();
        #1;
        check("t7_cleared", ov2, 1'b0);
        check("t7_allowin", a2, 1'b1);

        // Hold by mem_has_risk for three cycles, then flush; counters start from a fresh reset.
        do_reset();
        set_lane(0, 1, 5'd0, 32'hB000, 32'd0, 32'hB100, 1, 4'h1, 8'h3C, 0, 0, 5'h00);
        load_bundle();
        mem_has_risk = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("t8_hold_out_valid", ov2, 1'b0);
            check("t8_hold_allowin", a2, 1'b0);
            check("t8_hold_flush", fl2, 1'b0);
            check("t8_hold_has_risk", hr2, 1'b1);
            step();
        end
        mem_has_risk = 1'b0;
        #1 check("t8_flush_after_hold", fl2, 1'b1);
        step();
`ifdef BRANCH_AMEND_PERF_EN
        check("t8_perf_hold", ph2, 32'd3);
        check("t8_perf_mispred", pm2, 32'd1);
        check("t8_perf_hold4", ph4, 32'd3);
`else
        check("t8_perf_hold", ph2, 32'd0);
        check("t8_perf_mispred", pm2, 32'd0);
        check("t8_perf_hold4", ph4, 32'd0);
`endif
        check("t8_empty", ov2, 1'b0);

        // Asynchronous reset in the middle of a hold empties the stage with no flush.
        set_lane(0, 1, 5'd0, 32'hC000, 32'd0, 32'hC100, 1, 4'h1, 8'h12, 0, 0, 5'h00);
        load_bundle();
        mem_has_risk = 1'b1;
        step();
        #1 rst = 1'b0;
        #1;
        check("t9_rst_out_valid", ov2, 1'b0);
        check("t9_rst_allowin", a2, 1'b1);
        check("t9_rst_lanes", olv2, 2'b00);
        mem_has_risk = 1'b0;
        #1;
        check("t9_rst_flush", fl2, 1'b0);
        #1 rst = 1'b1;
        step();
        check("t9_after_flush", fl2, 1'b0);
        check("t9_after_out_valid", ov2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
